// File: rtl/instruction_tx.sv
// rtl/instruction_tx.sv - bit-serial instruction transmitter with ready/ack handshake
// Sends one WIDTH-bit word MSB first, one data_ready/data_ack handshake per bit.
module instruction_tx #(
    parameter int WIDTH          = 10,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ack,
    output logic             data_ready,
    output logic             data_bit,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam int SW = $clog2(SETUP_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_ACK,
        S_WAIT_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic             ack_meta;
    logic             ack_s;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic [SW-1:0]    setup_cnt;
    logic [TW-1:0]    wait_cnt;

    logic accept;
    logic wait_run;
    logic wait_expired;
    logic setup_met;
    logic bit_acked;

    // data_ack comes from another clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= data_ack;
            ack_s    <= ack_meta;
        end
    end

    always_comb begin
        accept       = (state == S_IDLE) && start;
        wait_run     = ((state == S_SETUP) && ack_s) ||
                       (state == S_WAIT_ACK) || (state == S_WAIT_RELEASE);
        wait_expired = wait_run && (wait_cnt == WAIT_LAST);
        setup_met    = (state == S_SETUP) && !ack_s && (setup_cnt == SETUP_LAST);
        bit_acked    = (state == S_WAIT_ACK) && ack_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (setup_met) begin
                    state_next = S_WAIT_ACK;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_WAIT_ACK: begin
                // The last bit skips the release wait; the receiver may keep ack high.
                if (ack_s) begin
                    state_next = (bit_cnt == LAST_BIT) ? S_DONE : S_WAIT_RELEASE;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_WAIT_RELEASE: begin
                if (!ack_s) begin
                    state_next = S_SETUP;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        data_ready = 1'b0;
        data_bit   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_SETUP: begin
                busy     = 1'b1;
                data_bit = shift_reg[WIDTH-1];
            end
            S_WAIT_ACK: begin
                busy       = 1'b1;
                data_ready = 1'b1;
                data_bit   = shift_reg[WIDTH-1];
            end
            S_WAIT_RELEASE: begin
                busy     = 1'b1;
                data_bit = shift_reg[WIDTH-1];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                shift_reg   <= word;
                bit_cnt     <= '0;
                timeout_err <= 1'b0;
            end else if (bit_acked) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + BW'(1);
            end

            if (state_next == S_ERROR) begin
                timeout_err <= 1'b1;
            end

            // Both counters restart on every state change.
            if (state_next != state) begin
                setup_cnt <= '0;
                wait_cnt  <= '0;
            end else begin
                if ((state == S_SETUP) && !ack_s) begin
                    setup_cnt <= setup_cnt + SW'(1);
                end
                if (wait_run) begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_tx.sv
// tb/tb_instruction_tx.sv - directed self-checking bench for instruction_tx
module tb_instruction_tx;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             data_ack = 1'b0;
    logic [WIDTH-1:0] word = '0;
    logic             data_ready;
    logic             data_bit;
    logic             busy;
    logic             done;
    logic             timeout_err;

    int vectors = 0;
    int miscompares = 0;

    logic prev_ready = 1'b0;
    logic prev_bit = 1'b0;

    localparam logic [WIDTH-1:0] W1 = 10'b1011001110;
    localparam logic [WIDTH-1:0] W2 = 10'b0101010011;
    localparam logic [WIDTH-1:0] W3 = 10'b1100101001;
    localparam logic [WIDTH-1:0] W4 = 10'b1001110110;
    localparam logic [WIDTH-1:0] W5 = 10'b0110011001;

    instruction_tx #(
        .WIDTH(WIDTH),
        .SETUP_CYCLES(2),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .word(word),
        .data_ack(data_ack),
        .data_ready(data_ready),
        .data_bit(data_bit),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // data_bit must hold while data_ready stays high
    always @(negedge clk) begin
        if (prev_ready && data_ready) begin
            vectors++;
            assert (data_bit === prev_bit) else begin
                miscompares++;
                $error("FAIL bit_stable: observed %0b expected %0b", data_bit, prev_bit);
            end
        end
        prev_ready = data_ready;
        prev_bit   = data_bit;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input logic val, input string tag);
        int n;
        n = 0;
        while (data_ready !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(data_ready), 32'(val));
    endtask

    task automatic send_start(input logic [WIDTH-1:0] w);
        word  = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_bit"}, 32'(data_bit), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic respond(input logic [WIDTH-1:0] w, input int nbits, input bit inject,
                           input bit hold_last);
        for (int i = 0; i < nbits; i++) begin
            wait_ready(1'b1, $sformatf("ready_rise_b%0d", i));
            check($sformatf("bit%0d", i), 32'(data_bit), 32'(w[WIDTH-1-i]));
            check($sformatf("busy_b%0d", i), 32'(busy), 32'd1);
            if (inject && i == 2) begin
                word  = ~w;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                word  = w;
                cycles(2);
            end else begin
                cycles(3);
            end
            data_ack = 1'b1;
            wait_ready(1'b0, $sformatf("ready_fall_b%0d", i));
            if (i == WIDTH - 1) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd0);
                @(negedge clk);
                check("done_once", 32'(done), 32'd0);
                check("busy_after_done", 32'(busy), 32'd0);
                if (!hold_last) begin
                    cycles(2);
                    data_ack = 1'b0;
                end
            end else begin
                check($sformatf("done_early_b%0d", i), 32'(done), 32'd0);
                cycles(3);
                data_ack = 1'b0;
            end
        end
    endtask

    initial begin
        int seen;

        cycles(3);
        check_all_zero("rst");
        start = 1'b1;
        word  = W1;
        @(negedge clk);
        start = 1'b0;
        check("rst_over_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // full word, ack released after every bit
        send_start(W1);
        check("w1_busy_start", 32'(busy), 32'd1);
        check("w1_ready_setup", 32'(data_ready), 32'd0);
        respond(W1, WIDTH, 1'b0, 1'b0);

        // start while busy is ignored; ack held high after the last bit
        cycles(2);
        send_start(W2);
        respond(W2, WIDTH, 1'b1, 1'b1);

        // new word while ack still high: no data_ready until ack_s falls
        send_start(W3);
        seen = 0;
        repeat (10) begin
            if (data_ready === 1'b1) seen++;
            @(negedge clk);
        end
        check("hold_no_ready", 32'(seen), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        data_ack = 1'b0;
        cycles(3);
        check("ready_before_setup_done", 32'(data_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(data_ready), 32'd1);
        respond(W3, WIDTH, 1'b0, 1'b0);

        // reset during WAIT_ACK of bit 5, then resend
        cycles(2);
        send_start(W4);
        respond(W4, 5, 1'b0, 1'b0);
        wait_ready(1'b1, "b5_ready");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        reset = 1'b0;
        @(negedge clk);
        send_start(W4);
        respond(W4, WIDTH, 1'b0, 1'b0);

        // receiver never acks
        cycles(2);
        send_start(W5);
        wait_ready(1'b1, "to_ready");
        cycles(999);
        check("to_terr_before", 32'(timeout_err), 32'd0);
        check("to_ready_before", 32'(data_ready), 32'd1);
        @(negedge clk);
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_ready", 32'(data_ready), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_terr_idle", 32'(timeout_err), 32'd1);
        check("to_busy_idle", 32'(busy), 32'd0);
        cycles(5);
        check("to_terr_sticky", 32'(timeout_err), 32'd1);
        send_start(W5);
        check("to_terr_cleared", 32'(timeout_err), 32'd0);
        check("to_busy_restart", 32'(busy), 32'd1);

        reset = 1'b1;
        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
